// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: parallel-RGB LCD timing generator with built-in test patterns
// (vertical/horizontal colour bars, checkerboard, grey ramp) on an NCLK = CLK/2 pixel clock.
`timescale 1ns/1ps
module lcd_pattern_gen #(
    parameter int H_ACT    = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 46,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 23,
    parameter int N_BARS   = 8,
    parameter int CDW      = 8,
    parameter int CHK_LOG2 = 5
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic [1:0]     MODE,
    output logic           NCLK,
    output logic           GREST,
    output logic           HD,
    output logic           VD,
    output logic           DEN,
    output logic [CDW-1:0] R,
    output logic [CDW-1:0] G,
    output logic [CDW-1:0] B,
    output logic           FRAME
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HA0   = H_SYNC + H_BP;
    localparam int VA0   = V_SYNC + V_BP;
    localparam int HBW   = H_ACT / N_BARS > 0 ? H_ACT / N_BARS : 1;
    localparam int VBW   = V_ACT / N_BARS > 0 ? V_ACT / N_BARS : 1;
    localparam int HW    = $clog2(H_TOT + 1);
    localparam int VW    = $clog2(V_TOT + 1);

    logic [HW-1:0]  hc;
    logic [VW-1:0]  vc;
    logic [1:0]     mode_q, md;
    logic           rs1, run, act, chk;
    logic [2:0]     idx, pal;
    logic [CDW-1:0] r_n, g_n, b_n;
    int             hn, vn, x, y, bar;

    // Everything below describes the position the next pixel tick will present.
    always_comb begin
        hn  = (!run || int'(hc) == H_TOT - 1) ? 0 : int'(hc) + 1;
        vn  = !run ? 0 : int'(hc) != H_TOT - 1 ? int'(vc) : int'(vc) == V_TOT - 1 ? 0 : int'(vc) + 1;
        md  = (hn == 0 && vn == 0) ? MODE : mode_q;
        x   = hn - HA0;
        y   = vn - VA0;
        act = hn >= HA0 && hn < HA0 + H_ACT && vn >= VA0 && vn < VA0 + V_ACT;
        bar = md[0] ? y / VBW : x / HBW;
        idx = bar > N_BARS - 1 ? 3'(N_BARS - 1) : 3'(bar);
        chk = x[CHK_LOG2] ^ y[CHK_LOG2];
        pal = md[1] ? {3{~chk}} : {~idx[1], ~idx[2], ~idx[0]};
        r_n = !act ? '0 : md == 2'b11 ? x[CDW-1:0] : {CDW{pal[2]}};
        g_n = !act ? '0 : md == 2'b11 ? x[CDW-1:0] : {CDW{pal[1]}};
        b_n = !act ? '0 : md == 2'b11 ? x[CDW-1:0] : {CDW{pal[0]}};
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            NCLK   <= 1'b0;
            rs1    <= 1'b0;
            GREST  <= 1'b0;
            run    <= 1'b0;
            hc     <= '0;
            vc     <= '0;
            mode_q <= 2'b00;
            HD     <= 1'b1;
            VD     <= 1'b1;
            DEN    <= 1'b0;
            R      <= '0;
            G      <= '0;
            B      <= '0;
            FRAME  <= 1'b0;
        end else begin
            NCLK  <= ~NCLK;
            rs1   <= 1'b1;
            GREST <= rs1;
            // Pixel tick: NCLK falls, so the panel sees stable data on its rising edge.
            if (NCLK && GREST) begin
                run    <= 1'b1;
                hc     <= HW'(hn);
                vc     <= VW'(vn);
                mode_q <= md;
                HD     <= hn >= H_SYNC;
                VD     <= vn >= V_SYNC;
                DEN    <= act;
                R      <= r_n;
                G      <= g_n;
                B      <= b_n;
                FRAME  <= hn == 0 && vn == 0;
            end
        end
    end
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: random pattern-mode changes and a mid-frame reset, every tick
// compared against a model computed from frame position (tick count) alone.
`timescale 1ns/1ps
module tb_lcd_pattern_gen;
    localparam logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic       CLK = 1'b0, RST_n = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic       NCLK, GREST, HD, VD, DEN, FRAME;
    logic [7:0] R, G, B;
    logic       NCLK3, GREST3, HD3, VD3, DEN3, FRAME3;
    logic [2:0] R3, G3, B3;
    int         checks = 0, errors = 0, k = 0, last = -1;
    logic [1:0] fmode = 2'b00;
    logic       hit = 1'b0;

    always #5 CLK = ~CLK;

    lcd_pattern_gen #(.H_ACT(16), .H_FP(2), .H_SYNC(1), .H_BP(3), .V_ACT(4), .V_FP(1),
                      .V_SYNC(1), .V_BP(2), .N_BARS(8), .CDW(8), .CHK_LOG2(1)) u_dut (
        .CLK(CLK), .RST_n(RST_n), .MODE(MODE), .NCLK(NCLK), .GREST(GREST), .HD(HD), .VD(VD),
        .DEN(DEN), .R(R), .G(G), .B(B), .FRAME(FRAME));

    lcd_pattern_gen #(.H_ACT(16), .H_FP(2), .H_SYNC(1), .H_BP(3), .V_ACT(4), .V_FP(1),
                      .V_SYNC(1), .V_BP(2), .N_BARS(8), .CDW(3), .CHK_LOG2(1)) u_dut3 (
        .CLK(CLK), .RST_n(RST_n), .MODE(MODE), .NCLK(NCLK3), .GREST(GREST3), .HD(HD3), .VD(VD3),
        .DEN(DEN3), .R(R3), .G(G3), .B(B3), .FRAME(FRAME3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Expected {HD,VD,DEN,FRAME,R,G,B} at line position h, line v, with cdw-bit channels.
    function automatic logic [27:0] model(input int h, input int v, input logic [1:0] m, input int cdw);
        int         x, y, bx;
        logic       den;
        logic [7:0] mask;
        logic [23:0] c;
        x    = h - 4;
        y    = v - 3;
        mask = 8'((1 << cdw) - 1);
        den  = h >= 4 && h < 20 && v >= 3 && v < 7;
        bx   = x / 2 > 7 ? 7 : x / 2;
        c    = 24'h0;
        if (den)
            case (m)
                2'b00:   c = PAL[bx];
                2'b01:   c = PAL[y];
                2'b10:   c = ((x / 2 + y / 2) % 2 == 0) ? 24'hFFFFFF : 24'h0;
                default: c = {3{8'(x % (1 << cdw))}};
            endcase
        c = c & {3{mask}};
        return {h >= 1, v >= 1, den, h == 0 && v == 0, c};
    endfunction

    task automatic reset_vals(input string tag);
        chk(tag, {NCLK, GREST, HD, VD, DEN, FRAME, R, G, B}, {6'b001100, 24'h0});
        chk({tag, "3"}, {NCLK3, GREST3, HD3, VD3, DEN3, FRAME3, R3, G3, B3}, {6'b001100, 9'h0});
    endtask

    task automatic start();
        RST_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1 reset_vals("reset");
        @(negedge CLK) RST_n = 1'b1;
        @(posedge CLK); #1 chk("grest_e1", GREST, 1'b0);
        @(posedge CLK); #1 chk("grest_e2", {GREST, GREST3}, 2'b11);
        @(posedge CLK); #1 chk("idle_e3", {HD, VD, FRAME}, 3'b110);
        k    = 0;
        last = -1;
    endtask

    task automatic run(input int n, input logic do_rst, output logic rst_hit);
        rst_hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            int          h, v;
            logic [27:0] e, e3;
            h = k % 22;
            v = (k / 22) % 8;
            if (h == 0 && v == 0) fmode = MODE;
            e  = model(h, v, fmode, 8);
            e3 = model(h, v, fmode, 3);
            @(posedge CLK); #1;
            chk("tick", {NCLK, HD, VD, DEN, FRAME, R, G, B}, {1'b0, e});
            chk("tick3", {NCLK3, HD3, VD3, DEN3, FRAME3, 5'b0, R3, 5'b0, G3, 5'b0, B3},
                {1'b0, e3[27:24], 5'b0, e3[18:16], 5'b0, e3[10:8], 5'b0, e3[2:0]});
            if (FRAME) begin
                if (last >= 0) chk("frame_period", 64'(k - last), 64'd176);
                last = k;
            end
            if (do_rst && k >= 352 && v == 5 && h == 7) begin
                #2 RST_n = 1'b0;
                #1 reset_vals("async_rst");
                rst_hit = 1'b1;
                return;
            end
            if (k == 88) MODE = 2'b10;
            else if (k > 176 && $urandom_range(0, 59) == 0) MODE = 2'($urandom_range(0, 3));
            @(posedge CLK); #1;
            chk("hold", {NCLK, HD, VD, DEN, FRAME, R, G, B}, {1'b1, e});
            k++;
        end
    endtask

    initial begin
        start();
        run(5 * 176, 1'b0, hit);
        run(3 * 176, 1'b1, hit);
        chk("rst_reached", hit, 1'b1);
        start();
        run(2 * 176 + 30, 1'b0, hit);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_pattern_gen.md
LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACT, default 800: active pixels per line.
REQ-002 SHALL have parameters H_FP=40, H_SYNC=1, H_BP=46: horizontal front porch, sync width and back porch, in pixels.
REQ-003 SHALL have parameters V_ACT=480, V_FP=22, V_SYNC=1, V_BP=23: vertical active, front porch, sync width and back porch, in lines.
REQ-004 SHALL have parameter N_BARS, default 8, legal range 1..8: bar count in bar modes.
REQ-005 SHALL have parameter CDW, default 8, legal range 1..8: width of each colour channel.
REQ-006 SHALL have parameter CHK_LOG2, default 5: checker square edge is 2^CHK_LOG2 pixels.
REQ-007 CLK  input  1  system clock.
REQ-008 RST_n  input  1  reset, asynchronous, active-low.
REQ-009 MODE  input  2  pattern select: 00 vertical bars, 01 horizontal bars, 10 checker, 11 grey ramp.
REQ-010 NCLK  output  1  panel pixel clock, CLK/2.
REQ-011 GREST  output  1  panel reset, active-low.
REQ-012 HD, VD  output  1 each  horizontal and vertical sync, active-low.
REQ-013 DEN  output  1  data enable, high during active pixels.
REQ-014 R, G, B  output  CDW each  pixel colour.
REQ-015 FRAME  output  1  frame-start strobe.

Function
REQ-016 NCLK SHALL toggle on every CLK rising edge. A pixel tick is the CLK edge on which NCLK goes 1->0.
REQ-017 hc and vc SHALL advance only on pixel ticks, so all outputs are stable at each NCLK rising edge.
REQ-018 H_TOT = H_SYNC+H_BP+H_ACT+H_FP. hc SHALL count 0..H_TOT-1 and wrap to 0.
REQ-019 V_TOT = V_SYNC+V_BP+V_ACT+V_FP. vc SHALL increment when hc wraps, and SHALL wrap to 0 after V_TOT-1.
REQ-020 Outputs SHALL be registered and updated on the same tick as the counters they describe. All outputs are mutually aligned and there is no extra pipeline skew.
REQ-021 HD SHALL be 0 when hc<H_SYNC. VD SHALL be 0 when vc<V_SYNC.
REQ-022 DEN SHALL be 1 when H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= vc < V_SYNC+V_BP+V_ACT.
REQ-023 Within the active area, x and y are the active-relative pixel and line indices, starting at 0.
REQ-024 When DEN=0, R, G and B SHALL all be 0.
REQ-025 The palette, by index, SHALL be: 0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black. Each channel is all-ones or zero.
REQ-026 Mode 00: bar index = x / (H_ACT/N_BARS), clamped to N_BARS-1, so the remainder pixels join the last bar.
REQ-027 Mode 01: same as mode 00, using y and V_ACT.
REQ-028 Mode 10: the pixel SHALL be white when x[CHK_LOG2] XOR y[CHK_LOG2] = 0, and black otherwise.
REQ-029 Mode 11: R=G=B=x[CDW-1:0], wrapping modulo 2^CDW.
REQ-030 MODE SHALL be sampled only on the tick where hc=0 and vc=0. A mid-frame MODE change SHALL take effect from the next frame.
REQ-031 FRAME SHALL be 1 for exactly one pixel period (2 CLK) while hc=0 and vc=0.
REQ-032 Division in REQ-026/027 SHALL be by elaboration-time constant. No runtime divider is allowed.

Reset
REQ-033 While RST_n=0, the block SHALL asynchronously force: NCLK=0, GREST=0, HD=1, VD=1, DEN=0, R=G=B=0, FRAME=0, hc=vc=0, latched mode=00.
REQ-034 GREST SHALL rise on the 2nd CLK rising edge after RST_n deasserts, using a two-flop release synchroniser.
REQ-035 The counters SHALL start at the first pixel tick after GREST=1. That tick presents hc=0, vc=0 with HD=0, VD=0, FRAME=1.
REQ-036 A reset asserted mid-frame SHALL abort the frame. Restart SHALL follow REQ-034/035.

Verification
Bench parameters for all scenarios: H_ACT=16, H_FP=2, H_SYNC=1, H_BP=3 (H_TOT=22); V_ACT=4, V_FP=1, V_SYNC=1, V_BP=2 (V_TOT=8); N_BARS=8, CDW=8, CHK_LOG2=1.
REQ-037 Reset release -> GREST=1 after 2 CLK edges. First tick gives HD=VD=0 and FRAME=1. FRAME repeats every 176 ticks (352 CLK).
REQ-038 MODE=00, line vc=3 -> DEN high for hc 4..19, 16 ticks. Colours run in 2-pixel bars white, yellow, cyan, green, magenta, red, blue, black. RGB=0 at hc 0..3 and 20..21.
REQ-039 Per line -> HD low for exactly 1 tick. VD low for all 22 ticks of vc=0. DEN never high when vc<3 or vc=7.
REQ-040 MODE=11 -> at x=15, R=G=B=0x0F. With CDW=3, x=9 gives 1 (wrap).
REQ-041 MODE switched 00->10 at vc=4 -> bars persist to frame end. Next frame shows checker: (x=0,y=0) white, (x=2,y=0) black, (x=2,y=2) white.
REQ-042 RST_n pulsed low at vc=5 -> all outputs immediately take the REQ-033 values. After release, the sequence of REQ-037 repeats exactly.
